i2c_target_rx: RTL and testbench

//  I2C target (slave) endpoint that sits directly downstream of the team's I2C master on the shared SCL/SDA pair.

---
 rtl/i2c_target_rx.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: I2C target endpoint. Synchronises SCL/SDA, detects START,
// repeated START and STOP, matches a 7-bit address, ACKs it, then receives
// write bytes or serves read bytes.
// Ports:
//   clk, reset_n     system clock, async active-low reset
//   scl, sda_in      asynchronous bus inputs
//   sda_oe           1 = pull SDA low (open drain)
//   rx_data/rx_valid received byte and 1-clk strobe
//   rx_ready         sink ready, sampled at the 8th data bit
//   tx_data/tx_req   read byte and 1-clk request for the next one
//   busy             transfer in progress (state != IDLE)
`timescale 1ns/1ps
module i2c_target_rx #(
   parameter logic [6:0]  DEVICE_ADDR = 7'h50,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       busy
);

   localparam int unsigned CNT_W = 3;

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK,
      S_WR_NACK, S_RD_DATA, S_RD_ACK, S_IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
   logic                   r_scl_d, r_sda_d;
   state_t                 r_state, w_state_nxt;
   logic [6:0]             r_shift, w_shift_nxt;
   logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nxt;
   logic                   r_rw, w_rw_nxt;
   logic                   r_phase, w_phase_nxt;
   logic                   r_sda_oe, w_sda_oe_nxt;
   logic [7:0]             r_rx_data, w_rx_data_nxt;
   logic                   r_rx_valid, w_rx_valid_nxt;
   logic                   r_tx_req, w_tx_req_nxt;
   logic                   r_busy, w_busy_nxt;

   logic       w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
   logic       w_last, w_addr_hit;
   logic [7:0] w_byte;

   // Input synchronisers plus one edge-detect flop; idle bus level is high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
         r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
         r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
      end
   end

   assign w_scl      = r_scl_sync[SYNC_STAGES-1];
   assign w_sda      = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   // SCL must be high on both samples so an SCL edge is never mistaken for a condition
   assign w_start    = ~w_sda & r_sda_d & w_scl & r_scl_d;
   assign w_stop     = w_sda & ~r_sda_d & w_scl & r_scl_d;
   assign w_byte     = {r_shift, w_sda};
   assign w_last     = (r_bit_cnt == CNT_W'(7));
   assign w_addr_hit = (w_byte[7:1] == DEVICE_ADDR);

   // State and datapath register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_rw      <= 1'b0;
         r_phase   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_rw      <= w_rw_nxt;
         r_phase   <= w_phase_nxt;
      end
   end

   // Next state; r_phase marks the second half of an ACK slot (or a seen master ACK)
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_cnt_nxt = r_bit_cnt;
      w_rw_nxt      = r_rw;
      w_phase_nxt   = r_phase;
      if (w_stop) begin
         w_state_nxt   = S_IDLE;
         w_bit_cnt_nxt = '0;
         w_phase_nxt   = 1'b0;
      end else if (w_start) begin
         w_state_nxt   = S_ADDR;
         w_bit_cnt_nxt = '0;
         w_phase_nxt   = 1'b0;
      end else begin
         case (r_state)
            S_ADDR: if (w_scl_rise) begin
               w_shift_nxt   = w_byte[6:0];
               w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
               if (w_last) begin
                  w_rw_nxt    = w_sda;
                  w_phase_nxt = 1'b0;
                  w_state_nxt = w_addr_hit ? S_ADDR_ACK : S_IGNORE;
               end
            end
            S_ADDR_ACK: if (w_scl_fall) begin
               if (!r_phase) begin
                  w_phase_nxt = 1'b1;
               end else begin
                  w_phase_nxt   = 1'b0;
                  w_bit_cnt_nxt = '0;
                  if (r_rw) begin
                     w_shift_nxt = tx_data[6:0];
                     w_state_nxt = S_RD_DATA;
                  end else begin
                     w_state_nxt = S_WR_DATA;
                  end
               end
            end
            S_WR_DATA: if (w_scl_rise) begin
               w_shift_nxt   = w_byte[6:0];
               w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
               if (w_last) begin
                  w_phase_nxt = 1'b0;
                  w_state_nxt = rx_ready ? S_WR_ACK : S_WR_NACK;
               end
            end
            S_WR_ACK: if (w_scl_fall) begin
               w_phase_nxt = ~r_phase;
               if (r_phase) w_state_nxt = S_WR_DATA;
            end
            S_WR_NACK: if (w_scl_fall) begin
               w_phase_nxt = ~r_phase;
               if (r_phase) w_state_nxt = S_IGNORE;
            end
            S_RD_DATA: if (w_scl_fall) begin
               if (w_last) begin
                  w_bit_cnt_nxt = '0;
                  w_phase_nxt   = 1'b0;
                  w_state_nxt   = S_RD_ACK;
               end else begin
                  w_shift_nxt   = {r_shift[5:0], 1'b0};
                  w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
               end
            end
            S_RD_ACK: begin
               if (w_scl_rise) begin
                  if (w_sda) w_state_nxt = S_IGNORE;
                  else       w_phase_nxt = 1'b1;
               end else if (w_scl_fall && r_phase) begin
                  w_phase_nxt = 1'b0;
                  w_shift_nxt = tx_data[6:0];
                  w_state_nxt = S_RD_DATA;
               end
            end
            default: ;
         endcase
      end
   end

   // Output next values; sda_oe only moves on a detected SCL fall (or START/STOP)
   always_comb begin
      w_sda_oe_nxt   = r_sda_oe;
      w_rx_data_nxt  = r_rx_data;
      w_rx_valid_nxt = 1'b0;
      w_tx_req_nxt   = 1'b0;
      w_busy_nxt     = (w_state_nxt != S_IDLE);
      if (w_stop || w_start) begin
         w_sda_oe_nxt = 1'b0;
      end else begin
         case (r_state)
            S_ADDR: if (w_scl_rise && w_last && w_addr_hit && w_sda) w_tx_req_nxt = 1'b1;
            S_ADDR_ACK: if (w_scl_fall) begin
               if (!r_phase) w_sda_oe_nxt = 1'b1;
               else          w_sda_oe_nxt = r_rw & ~tx_data[7];
            end
            S_WR_DATA: if (w_scl_rise && w_last && rx_ready) begin
               w_rx_data_nxt  = w_byte;
               w_rx_valid_nxt = 1'b1;
            end
            S_WR_ACK:  if (w_scl_fall) w_sda_oe_nxt = ~r_phase;
            S_RD_DATA: if (w_scl_fall) w_sda_oe_nxt = ~w_last & ~r_shift[6];
            S_RD_ACK: begin
               if (w_scl_rise && !w_sda) w_tx_req_nxt = 1'b1;
               if (w_scl_fall && r_phase) w_sda_oe_nxt = ~tx_data[7];
            end
            default: w_sda_oe_nxt = 1'b0;
         endcase
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sda_oe   <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_tx_req   <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_sda_oe   <= w_sda_oe_nxt;
         r_rx_data  <= w_rx_data_nxt;
         r_rx_valid <= w_rx_valid_nxt;
         r_tx_req   <= w_tx_req_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   assign sda_oe   = r_sda_oe;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign tx_req   = r_tx_req;
   assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx: bench for i2c_target_rx. A bus-level master model drives
// frames; expectations come from a transaction-level model of the target.
`timescale 1ns/1ps
module tb_i2c_target_rx;

   localparam logic [6:0] DEV  = 7'h50;
   localparam int         TLO  = 8;
   localparam int         THI  = 8;
   localparam int         TSMP = 5;

   logic       clk = 1'b0;
   logic       reset_n, scl, m_sda, rx_ready;
   logic [7:0] tx_data;
   logic       sda_oe, rx_valid, tx_req, busy;
   logic [7:0] rx_data;
   logic       sda_bus;

   assign sda_bus = m_sda & ~sda_oe;

   i2c_target_rx #(.DEVICE_ADDR(DEV), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .scl(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
   );

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_err = 0;
   int         tx_cnt = 0;
   int         rd_base = 0;
   logic [7:0] rd_q [8];
   logic [7:0] wr_d [8];
   logic       wr_rdy [8];
   logic [7:0] rx_q [$];
   logic [7:0] exp_rx [$];
   logic       prev_rxv = 1'b0;
   logic       prev_txr = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Strobe monitor: collects received bytes, serves read bytes on tx_req
   always @(negedge clk) begin
      if (rx_valid) begin
         check("rx_valid_width", 32'(prev_rxv), 32'd0);
         rx_q.push_back(rx_data);
      end
      if (tx_req) begin
         check("tx_req_width", 32'(prev_txr), 32'd0);
         tx_data = rd_q[(tx_cnt - rd_base) & 7];
         tx_cnt++;
      end
      prev_rxv = rx_valid;
      prev_txr = tx_req;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCL period starting just after a fall; returns the bus level mid-high
   task automatic do_bit(input logic b, output logic s);
      wait_clk(2);
      m_sda = b;
      wait_clk(TLO - 2);
      scl = 1'b1;
      wait_clk(TSMP);
      s = sda_bus;
      wait_clk(THI - TSMP);
      scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic [7:0] echo);
      logic s;
      for (int k = 7; k >= 0; k--) begin
         do_bit(b[k], s);
         echo[k] = s;
      end
   endtask

   task automatic bus_start();
      wait_clk(4);
      m_sda = 1'b0;
      wait_clk(6);
      scl = 1'b0;
   endtask

   task automatic bus_rstart();
      wait_clk(2);
      m_sda = 1'b1;
      wait_clk(6);
      scl = 1'b1;
      wait_clk(6);
      m_sda = 1'b0;
      wait_clk(6);
      scl = 1'b0;
   endtask

   task automatic bus_stop();
      wait_clk(2);
      m_sda = 1'b0;
      wait_clk(6);
      scl = 1'b1;
      wait_clk(6);
      m_sda = 1'b1;
      wait_clk(8);
   endtask

   // End-of-frame checks: bus idle, received bytes and read requests as modelled
   task automatic check_end(input int exp_tx);
      int n;
      check("busy_after_stop", 32'(busy), 32'd0);
      check("sda_oe_after_stop", 32'(sda_oe), 32'd0);
      check("tx_req_count", 32'(tx_cnt - rd_base), 32'(exp_tx));
      check("rx_count", 32'(rx_q.size()), 32'(exp_rx.size()));
      n = (rx_q.size() < exp_rx.size()) ? rx_q.size() : exp_rx.size();
      for (int i = 0; i < n; i++) check($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_rx[i]));
      rx_q.delete();
      exp_rx.delete();
   endtask

   // Write frame: address, n bytes from wr_d with wr_rdy sink readiness, STOP
   task automatic wr_txn(input logic [6:0] a, input int n);
      logic [7:0] echo;
      logic       s;
      logic       ign;
      rd_base = tx_cnt;
      ign = (a != DEV);
      bus_start();
      check("busy_after_start", 32'(busy), 32'd1);
      send_byte({a, 1'b0}, echo);
      check("wr_addr_echo", 32'(echo), 32'({a, 1'b0}));
      do_bit(1'b1, s);
      check("wr_addr_ack", 32'(s), 32'(ign));
      for (int i = 0; i < n; i++) begin
         rx_ready = wr_rdy[i];
         send_byte(wr_d[i], echo);
         check("wr_echo", 32'(echo), 32'(wr_d[i]));
         do_bit(1'b1, s);
         if (!ign && wr_rdy[i]) begin
            check("wr_data_ack", 32'(s), 32'd0);
            exp_rx.push_back(wr_d[i]);
         end else begin
            check("wr_data_nack", 32'(s), 32'd1);
            ign = 1'b1;
         end
      end
      check("busy_before_stop", 32'(busy), 32'd1);
      bus_stop();
      check_end(0);
   endtask

   // Read frame: address, n bytes (master ACKs all but the last), STOP
   task automatic rd_txn(input logic [6:0] a, input int n);
      logic [7:0] echo, v;
      logic       s;
      logic       hit;
      hit = (a == DEV);
      for (int i = 0; i < 8; i++) rd_q[i] = 8'($urandom);
      rd_base = tx_cnt;
      bus_start();
      send_byte({a, 1'b1}, echo);
      check("rd_addr_echo", 32'(echo), 32'({a, 1'b1}));
      do_bit(1'b1, s);
      check("rd_addr_ack", 32'(s), 32'(!hit));
      for (int i = 0; i < n; i++) begin
         send_byte(8'hFF, v);
         check($sformatf("rd_byte%0d", i), 32'(v), hit ? 32'(rd_q[i]) : 32'hFF);
         do_bit((i == n - 1), s);
      end
      bus_stop();
      check_end(hit ? n : 0);
   endtask

   initial begin
      logic [7:0] echo;
      logic       s;
      int         n;
      logic [6:0] a;

      scl = 1'b1; m_sda = 1'b1; rx_ready = 1'b0; tx_data = 8'h00;
      reset_n = 1'b0;
      wait_clk(3);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_tx_req", 32'(tx_req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      wait_clk(4);

      // Two-byte write to our address
      wr_d[0] = 8'hA5; wr_d[1] = 8'h3C; wr_rdy[0] = 1'b1; wr_rdy[1] = 1'b1;
      wr_txn(DEV, 2);
      check("rx_data_last", 32'(rx_data), 32'h3C);

      // Foreign address
      wr_d[0] = 8'h11; wr_rdy[0] = 1'b1;
      wr_txn(7'h51, 1);

      // Read two bytes, fixed values
      rd_base = tx_cnt;
      rd_q[0] = 8'hC3; rd_q[1] = 8'h81;
      bus_start();
      send_byte({DEV, 1'b1}, echo);
      do_bit(1'b1, s);
      check("rd_fixed_addr_ack", 32'(s), 32'd0);
      send_byte(8'hFF, echo);
      check("rd_fixed_b0", 32'(echo), 32'hC3);
      do_bit(1'b0, s);
      send_byte(8'hFF, echo);
      check("rd_fixed_b1", 32'(echo), 32'h81);
      do_bit(1'b1, s);
      wait_clk(4);
      check("rd_nack_release", 32'(sda_oe), 32'd0);
      bus_stop();
      check_end(2);

      // Sink not ready: NACK, rest of frame ignored
      wr_d[0] = 8'h77; wr_d[1] = 8'h12; wr_rdy[0] = 1'b0; wr_rdy[1] = 1'b1;
      wr_txn(DEV, 2);

      // Repeated START after half a data byte, then a one-byte read
      rd_base = tx_cnt;
      rd_q[0] = 8'h6E;
      rx_ready = 1'b1;
      bus_start();
      send_byte({DEV, 1'b0}, echo);
      do_bit(1'b1, s);
      check("rs_wr_addr_ack", 32'(s), 32'd0);
      for (int k = 0; k < 4; k++) do_bit(k[0], s);
      bus_rstart();
      send_byte({DEV, 1'b1}, echo);
      do_bit(1'b1, s);
      check("rs_rd_addr_ack", 32'(s), 32'd0);
      send_byte(8'hFF, echo);
      check("rs_rd_byte", 32'(echo), 32'h6E);
      do_bit(1'b1, s);
      bus_stop();
      check_end(1);

      // Reset while the address ACK is being driven
      rd_base = tx_cnt;
      bus_start();
      send_byte({DEV, 1'b0}, echo);
      wait_clk(4);
      check("ack_driven", 32'(sda_oe), 32'd1);
      reset_n = 1'b0;
      #1;
      check("async_rst_sda_oe", 32'(sda_oe), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      wait_clk(3);
      reset_n = 1'b1;
      wait_clk(3);
      bus_stop();
      check_end(0);
      wr_d[0] = 8'h5A; wr_rdy[0] = 1'b1;
      wr_txn(DEV, 1);
      check("rx_data_after_rst", 32'(rx_data), 32'h5A);

      // Randomised frames
      for (int it = 0; it < 20; it++) begin
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : DEV;
         n = $urandom_range(1, 4);
         if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i < 8; i++) begin
               wr_d[i]   = 8'($urandom);
               wr_rdy[i] = ($urandom_range(0, 4) != 0);
            end
            wr_txn(a, n);
         end else begin
            rd_txn(a, n);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
